// File: rtl/dmem_pkg.sv
// Shared types, constants and the address legality helper for the
// data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam logic [31:0] DMEM_ERR_DATA = 32'hDEADBEEF;
  localparam logic [31:0] DATA_SEG_BASE = 32'h10010000;

  // Word-aligned and inside [base, base + 4*depth). The offset is formed
  // with 32-bit unsigned subtraction; an address below base wraps to a huge
  // offset, but the explicit addr >= base term rejects it regardless.
  function automatic logic addr_legal(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int unsigned depth);
    logic [32:0] off;
    logic [32:0] lim;
    off = {1'b0, addr - base};
    lim = {1'b0, depth} << 2;
    return (addr[1:0] == 2'b00) && (addr >= base) && (off < lim);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the CPU data port and the responder.
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both 1. The producer holds valid and its payload
// steady until that edge; the consumer may raise or drop ready at any time.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_array.sv
// Single-port word storage with per-byte write enables. Read data is
// registered on the enabled edge and otherwise holds its last value.
// Contents are deliberately not reset.
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IW          = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [IW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane write and registered read of the addressed word.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target with a programmable number of wait states between
// request acceptance and the storage access. One request in flight at a
// time: IDLE accepts, WAIT burns LATENCY cycles, RESP holds the answer
// until the CPU takes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = DATA_SEG_BASE,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  dmem_responder_if.slave bus,
  output dmem_state_t dbg_state
);

  localparam int unsigned IW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  if (LATENCY > 15) begin : g_latency_check
    $error("dmem_responder: LATENCY must be in 0..15");
  end

  dmem_state_t state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        accept, access;

  // Latched request, used by accesses performed after a WAIT phase.
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;

  // Response side: error flag and store flag captured on the access edge.
  logic        err_q;
  logic        rsp_we_q;

  // Access operands: live inputs for the zero-latency path, latch otherwise.
  logic          acc_we;
  logic [31:0]   acc_addr, acc_wdata;
  logic [3:0]    acc_be;
  logic          acc_legal;
  logic [IW-1:0] acc_idx;
  logic [31:0]   arr_rdata;

  // Pick the operands of the access happening on this edge.
  always_comb begin
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    if (state == IDLE) begin
      acc_we    = bus.req_we;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
      acc_be    = bus.req_be;
    end
  end

  assign acc_legal = addr_legal(acc_addr, BASE_ADDR, DEPTH_WORDS);
  assign acc_idx   = IW'((acc_addr - BASE_ADDR) >> 2);

  // Next-state and strobe logic.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    access   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            access   = 1'b1;
            state_nx = RESP;
          end else begin
            cnt_nx   = LAT_LOAD;
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          access   = 1'b1;
          state_nx = RESP;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, counter, request latch and response flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      be_q     <= 4'd0;
      err_q    <= 1'b0;
      rsp_we_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        be_q    <= bus.req_be;
      end
      if (access) begin
        err_q    <= ~acc_legal;
        rsp_we_q <= acc_we;
      end
    end
  end

  // Illegal accesses never enable the array, so they cannot write.
  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IW          (IW)
  ) u_array (
    .clk   (clk),
    .en    (access & acc_legal),
    .we    (acc_we),
    .be    (acc_be),
    .idx   (acc_idx),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  // Array read data only moves on an access edge, so the held response is
  // immune to anything happening on the request side while in RESP.
  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_err   = (state == RESP) & err_q;
  assign bus.rsp_rdata = (state != RESP) ? 32'd0 :
                         err_q           ? DMEM_ERR_DATA :
                         rsp_we_q        ? 32'd0 : arr_rdata;
  assign dbg_state     = state;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory target that answers CPU load/store requests over a valid/ready request channel and a valid/ready response channel.
- Inserts a programmable number of wait states per access, so the CPU datapath can be tested against a non-ideal memory.
- Sits between the CPU data port and the word-aligned data-segment storage. It replaces the combinational data memory in multi-cycle and pipelined CPU variants.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words stored.
- BASE_ADDR, 32'h10010000: byte address of word 0 (start of the data segment).
- LATENCY, 2: wait cycles between request acceptance and the memory access, range 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables for the store; bit i writes byte lane i, bits [8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  CPU accepts the response.
- rsp_rdata  out  32  load data; 32'h00000000 for a successful store.
- rsp_err  out  1  access rejected.

Behaviour:
- Reset values (rst low, asynchronous): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. Storage contents are not affected by reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - A request is accepted on an edge where req_valid=1. On acceptance, latch we/addr/wdata/be.
  - If LATENCY>0: load counter=LATENCY-1 and go to WAIT. If LATENCY=0: perform the access on the same edge and go to RESP.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - When counter==0: perform the access on that edge and go to RESP.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_err are held stable until the handshake.
  - On an edge where rsp_ready=1: go to IDLE with rsp_valid=0.
  - req_ready=0 in RESP; no back-to-back acceptance in the handshake cycle.
- Timing: rsp_valid rises LATENCY+1 edges after the acceptance edge. Minimum request-to-request spacing is LATENCY+2 cycles.
- Access legality:
  - index = (addr-BASE_ADDR)>>2.
  - Legal only if addr[1:0]==0 and BASE_ADDR <= addr < BASE_ADDR+4*DEPTH_WORDS. Subtraction is 32-bit unsigned; underflow counts as out of range.
- Legal load: rsp_rdata = word at index, rsp_err=0.
- Legal store: enabled lanes written, other lanes unchanged; rsp_rdata=0, rsp_err=0.
- Store with req_be=4'b0000: legal no-op, rsp_err=0.
- Illegal access: no write; rsp_rdata=32'hDEADBEEF, rsp_err=1.
- Response data is registered: it is sampled from storage on the access edge, and a later store cannot change a held response.
- Inputs are ignored outside IDLE. req_* may change freely while req_ready=0.
- Reset mid-operation:
  - In WAIT, the pending store is discarded (no write) and no response is issued.
  - In RESP, the response is dropped.
  - An access already performed before reset stays in storage.
- Counter width is 4 bits. LATENCY>15 is a parameter error, flagged by an elaboration-time check.

Decomposition:
- Package dmem_pkg:
  - state enum dmem_state_t {IDLE, WAIT, RESP}.
  - constants DMEM_ERR_DATA=32'hDEADBEEF and DATA_SEG_BASE=32'h10010000.
  - function addr_legal(addr, base, depth).
- Sub-module dmem_array:
  - synchronous single-port storage: clk, en, we, be[3:0], idx, wdata, rdata.
  - rdata registered on the edge en is asserted.
  - no reset.
- dmem_responder holds the FSM, counter, request latch and legality check.

Test Plan:
1. LATENCY=2: store addr 32'h10010004, data 32'hCAFEF00D, be=4'hF, then load the same address -> each rsp_valid rises 3 edges after acceptance; load returns rdata=32'hCAFEF00D, err=0; req_ready=0 throughout WAIT/RESP.
2. Byte enables: store 32'h11223344 be=F to 32'h10010000, then store 32'hAABBCCDD be=4'b0101 to the same address; load -> rdata=32'h11BB33DD.
3. Errors:
   - load 32'h10010002 -> err=1, rdata=32'hDEADBEEF.
   - store to 32'h10011000 (DEPTH_WORDS=1024) -> err=1, and a follow-up load of 32'h10010FFC is unchanged.
   - load 32'h0000FFFC -> err=1.
4. Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid; issue a store to the same word meanwhile -> rsp_rdata stable, req_ready=0, store not accepted until the RESP handshake completes.
5. Reset mid-operation: LATENCY=3; assert rst low one cycle after accepting a store of 32'h12345678 to 32'h10010008 (old value 32'h0BADF00D) -> rsp_valid=0, req_ready=1 immediately; a later load returns 32'h0BADF00D.
6. LATENCY=0 with rsp_ready tied to 1: store then load 32'h10010010 -> rsp_valid 1 edge after acceptance, one request per 2 cycles, load returns the stored value.
